// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: turns a one-cycle load/store into a fixed-latency
// memory transaction, stalling upstream and retiring to writeback. Option: MEM_STAGE_WBUF_EN.
module mem_stage_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [3:0]        ex_dstreg,
  output logic              stall,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [3:0]        wb_dstreg,
  output logic [DATA_W-1:0] wb_rdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

`ifdef MEM_STAGE_WBUF_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          dst_q, dst_d;
  logic                load_q, load_d;
  logic [3:0]          wb_dstreg_q, wb_dstreg_d;
  logic [DATA_W-1:0]   wb_rdata_q, wb_rdata_d;
  logic                req;

  assign req = ex_valid & (ex_memread | ex_memwrite);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    dst_d       = dst_q;
    load_d      = load_q;
    wb_dstreg_d = wb_dstreg_q;
    wb_rdata_d  = wb_rdata_q;
    stall       = 1'b0;
    wb_valid    = 1'b0;
    wb_regwrite = 1'b0;
    mem_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = ex_addr;
          wdata_d = ex_wdata;
          dst_d   = ex_dstreg;
          // read wins when both op bits are set, so no write can leak out
          load_d  = ex_memread;
          cnt_d   = CNT_INIT;
`ifdef MEM_STAGE_WBUF_EN
          if (!ex_memread) begin
            state_d    = DRAIN;
            wb_rdata_d = '0;
          end else begin
            stall   = 1'b1;
            state_d = BUSY;
          end
`else
          stall   = 1'b1;
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        mem_en = 1'b1;
        stall  = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (load_q) begin
            wb_rdata_d  = mem_rdata;
            wb_dstreg_d = dst_q;
          end else begin
            wb_rdata_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        wb_valid    = 1'b1;
        wb_regwrite = load_q;
        state_d     = IDLE;
      end
`ifdef MEM_STAGE_WBUF_EN
      DRAIN: begin
        // buffered store retires on the first drain cycle; later requests wait it out
        mem_en   = 1'b1;
        stall    = req;
        wb_valid = (cnt_q == CNT_INIT);
        if (cnt_q == 4'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign mem_wr    = mem_en & ~load_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign wb_dstreg = wb_dstreg_q;
  assign wb_rdata  = wb_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      dst_q       <= '0;
      load_q      <= 1'b0;
      wb_dstreg_q <= '0;
      wb_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      dst_q       <= dst_d;
      load_q      <= load_d;
      wb_dstreg_q <= wb_dstreg_d;
      wb_rdata_q  <= wb_rdata_d;
    end
  end

endmodule
